rr_grant_dispatch: RTL and testbench
====================================

# rr_grant_dispatch

Requester-side companion to the round-robin arbiter. Tracks pending transactions for each of REQCNT clients and presents the pending mask to the arbiter as a request vector. Accepts the arbiter's granted number and turns it into a one-hot grant with a valid/ready handshake toward the downstream consumer. Sits between the client interfaces and the arbiter; one dispatch per arbiter instance.

## Interface
- REQCNT, 5, number of clients
- REQWIDTH, $clog2(REQCNT), width of granted number
- CNTWIDTH, 4, width of each client's pending counter (max 2^CNTWIDTH-1)
- ARB_LAT, 2, cycles from arb_req_o assertion until arb_num_val_i/arb_num_i are trustworthy
- TIMEOUT, 16, cycles in WAIT_GNT before abandoning (TIMEOUT > ARB_LAT)

Ports:
- clk_i  in  1  clock; all logic on posedge
- rst_i  in  1  reset, synchronous, active-low
- cli_req_i  in  REQCNT  per-client one-cycle pulse: add one pending transaction
- cli_full_o  out  REQCNT  bit i high while client i's counter is at max
- arb_req_o  out  REQCNT  request vector to arbiter (registered)
- arb_num_i  in  REQWIDTH  granted client number from arbiter
- arb_num_val_i  in  1  arb_num_i valid
- gnt_o  out  REQCNT  one-hot grant to downstream
- gnt_val_o  out  1  gnt_o valid
- gnt_ready_i  in  1  downstream accepts grant
- drop_o  out  1  one-cycle pulse: invalid grant discarded
- timeout_o  out  1  one-cycle pulse: WAIT_GNT abandoned

## Operation
- Pending counter per client. Increment on cli_req_i[i] unless full. Decrement on the grant handshake for i. Both in the same cycle leave the count unchanged. A pulse while full is silently ignored; at max the count neither saturates further nor wraps.
- cli_full_o[i] = (cnt[i] == 2^CNTWIDTH-1), combinational from the counter.
- FSM states:
  - IDLE: if any cnt != 0, snapshot mask[i] = (cnt[i] != 0), set arb_req_o = mask, clear wait_cnt, go to WAIT_GNT.
  - WAIT_GNT: arb_req_o holds the snapshot and wait_cnt increments.
    - When wait_cnt >= ARB_LAT and arb_num_val_i: capture arb_num_i and clear arb_req_o.
    - Captured number < REQCNT and mask[num] set: go to OFFER.
    - Otherwise: pulse drop_o and go to IDLE.
    - When wait_cnt == TIMEOUT-1 with no accepted grant: pulse timeout_o, clear arb_req_o, go to IDLE.
  - OFFER: gnt_val_o = 1, gnt_o = one-hot(num), both stable until gnt_ready_i. On gnt_val_o && gnt_ready_i: decrement cnt[num], go to IDLE.
- arb_num_val_i is ignored outside WAIT_GNT and during the first ARB_LAT cycles of WAIT_GNT.
- Number-to-one-hot conversion: an out-of-range value never reaches gnt_o.

## Timing
- Reset (rst_i low at a posedge): all counters 0, FSM IDLE, arb_req_o 0, gnt_o 0, gnt_val_o 0, drop_o 0, timeout_o 0, cli_full_o 0. Reset mid-handshake discards the in-flight grant; no decrement occurs.
- Request path:
  - cli_req_i at cycle t → cnt updated at t+1.
  - FSM samples cnt at t+1 → arb_req_o high at t+2.
- Grant path:
  - First accepted arb_num_val_i is at t+2+ARB_LAT.
  - gnt_val_o is high the cycle after acceptance.
- Handshake: the decrement and the return to IDLE are visible the cycle after gnt_ready_i. The next arb_req_o can rise one cycle later. Minimum grant-to-grant spacing is ARB_LAT+3 cycles with gnt_ready_i tied high.
- gnt_val_o never drops without a handshake, except on reset.
- Snapshot mask is fixed for the whole WAIT_GNT. New client requests arriving during WAIT_GNT or OFFER only appear at the next IDLE.

## Structure
- Shared package rr_pkg holds:
  - typedef enum for FSM states {IDLE, WAIT_GNT, OFFER}
  - function num_to_onehot(num) returning REQCNT bits, zero if num >= REQCNT
- Sub-module rr_pending_cnt: one pending counter with inc/dec/full, instantiated REQCNT times via generate.
- The FSM, wait counter and grant register live in rr_grant_dispatch.

## Test plan
All scenarios use REQCNT=5, ARB_LAT=2, TIMEOUT=16 and a behavioral arbiter model.
- Reset release, no requests → all outputs 0 for 20 cycles, FSM IDLE.
- Single request:
  - Stimulus: cli_req_i=5'b00100 at t, model answers num=2, gnt_ready_i=1.
  - Required: arb_req_o=00100 at t+2; gnt_o=00100 with gnt_val_o at t+5; cnt[2] back to 0; arb_req_o=0 afterwards.
- Full and simultaneous:
  - Stimulus: 16 pulses on client 0.
  - Required: cnt=15 and cli_full_o[0]=1; the 16th pulse is ignored.
  - Stimulus: inc and handshake for client 0 in the same cycle.
  - Required: cnt stays 15.
- Bad grant:
  - Stimulus: mask=00010, model returns num=3, then on retry num=6.
  - Required: drop_o pulses each time; no gnt_val_o; cnt[1] unchanged at 1.
- Timeout: model never asserts arb_num_val_i → timeout_o pulses 16 cycles after arb_req_o rose, arb_req_o falls, re-arbitration follows.
- Backpressure then reset:
  - Stimulus: gnt_ready_i=0 for 10 cycles.
  - Required: gnt_o and gnt_val_o stable throughout.
  - Stimulus: rst_i low in the middle of that window.
  - Required: all outputs 0 the next cycle; counters 0.

Source files
------------

// File: rtl/rr_pkg.sv
// Shared definitions for the round-robin grant dispatch block: the dispatch
// FSM state type and the client-number to one-hot conversion helper.
package rr_pkg;

    // Widest one-hot vector the conversion helper can produce.
    localparam int ONEHOT_MAX = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        OFFER    = 2'd2
    } rr_state_e;

    // One-hot of num within a reqcnt-wide client space; all zeros when num is
    // out of range, so a bogus arbiter answer can never select a client.
    function automatic logic [ONEHOT_MAX-1:0] num_to_onehot(
        input logic [ONEHOT_MAX-1:0] num,
        input int unsigned           reqcnt
    );
        logic [ONEHOT_MAX-1:0] oh;
        oh = '0;
        for (int i = 0; i < ONEHOT_MAX; i++) begin
            if ((i < reqcnt) && (num == ONEHOT_MAX'(i))) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/rr_pending_cnt.sv
// Pending-transaction counter for one client. Increments on a client pulse
// unless full, decrements on the grant handshake, holds when both coincide.
module rr_pending_cnt
    import rr_pkg::*;
#(
    parameter int CNTWIDTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                inc_i,
    input  logic                dec_i,
    output logic [CNTWIDTH-1:0] cnt_o,
    output logic                full_o
);

    localparam logic [CNTWIDTH-1:0] CNT_MAX = '1;

    logic [CNTWIDTH-1:0] cnt_q;
    logic [CNTWIDTH-1:0] cnt_d;

    assign full_o = (cnt_q == CNT_MAX);
    assign cnt_o  = cnt_q;

    // Next count: simultaneous inc/dec cancel; a pulse at max is dropped.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && dec_i) begin
            cnt_d = cnt_q;
        end else if (inc_i && !full_o) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rr_grant_dispatch.sv
// Requester-side companion to the round-robin arbiter: tracks per-client
// pending work, presents a snapshot request mask to the arbiter, validates
// the returned client number and offers it downstream as a one-hot grant.
module rr_grant_dispatch
    import rr_pkg::*;
#(
    parameter int REQCNT   = 5,
    parameter int REQWIDTH = $clog2(REQCNT),
    parameter int CNTWIDTH = 4,
    parameter int ARB_LAT  = 2,
    parameter int TIMEOUT  = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [REQCNT-1:0]   cli_req_i,
    output logic [REQCNT-1:0]   cli_full_o,
    output logic [REQCNT-1:0]   arb_req_o,
    input  logic [REQWIDTH-1:0] arb_num_i,
    input  logic                arb_num_val_i,
    output logic [REQCNT-1:0]   gnt_o,
    output logic                gnt_val_o,
    input  logic                gnt_ready_i,
    output logic                drop_o,
    output logic                timeout_o
);

    // Wait counter only needs to reach TIMEOUT-1.
    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0] LAT_C  = WCW'(ARB_LAT);
    localparam logic [WCW-1:0] LAST_C = WCW'(TIMEOUT - 1);

    rr_state_e           state_q, state_d;
    logic [REQCNT-1:0]   mask_q, mask_d;
    logic [REQCNT-1:0]   arb_req_q, arb_req_d;
    logic [REQCNT-1:0]   gnt_q, gnt_d;
    logic [WCW-1:0]      wait_q, wait_d;
    logic                drop_q, drop_d;
    logic                tout_q, tout_d;

    logic [CNTWIDTH-1:0] cnt_w [REQCNT];
    logic [REQCNT-1:0]   pend_w;
    logic [REQCNT-1:0]   dec_w;
    logic                hs_w;
    logic [ONEHOT_MAX-1:0] num_oh_w;
    logic [REQCNT-1:0]   num_sel_w;
    logic                num_ok_w;

    for (genvar g = 0; g < REQCNT; g++) begin : g_cnt
        rr_pending_cnt #(
            .CNTWIDTH (CNTWIDTH)
        ) u_cnt (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .inc_i  (cli_req_i[g]),
            .dec_i  (dec_w[g]),
            .cnt_o  (cnt_w[g]),
            .full_o (cli_full_o[g])
        );
        assign pend_w[g] = (cnt_w[g] != '0);
    end

    // Grant handshake retires exactly the offered client.
    assign hs_w  = (state_q == OFFER) && gnt_ready_i;
    assign dec_w = hs_w ? gnt_q : '0;

    // Arbiter answer is usable only if in range and part of the snapshot.
    assign num_oh_w  = num_to_onehot(ONEHOT_MAX'(arb_num_i), REQCNT);
    assign num_sel_w = num_oh_w[REQCNT-1:0] & mask_q;
    assign num_ok_w  = (|num_oh_w) && (|num_sel_w);

    assign arb_req_o = arb_req_q;
    assign gnt_o     = gnt_q;
    assign gnt_val_o = (state_q == OFFER);
    assign drop_o    = drop_q;
    assign timeout_o = tout_q;

    // Dispatch FSM: snapshot pending clients, wait for a trustworthy
    // arbiter answer (or give up), then hold the grant until accepted.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        arb_req_d = arb_req_q;
        gnt_d     = gnt_q;
        wait_d    = wait_q;
        drop_d    = 1'b0;
        tout_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|pend_w) begin
                    mask_d    = pend_w;
                    arb_req_d = pend_w;
                    wait_d    = '0;
                    state_d   = WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                wait_d = wait_q + 1'b1;
                if ((wait_q >= LAT_C) && arb_num_val_i) begin
                    arb_req_d = '0;
                    if (num_ok_w) begin
                        gnt_d   = num_oh_w[REQCNT-1:0];
                        state_d = OFFER;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else if (wait_q == LAST_C) begin
                    tout_d    = 1'b1;
                    arb_req_d = '0;
                    state_d   = IDLE;
                end
            end
            OFFER: begin
                if (gnt_ready_i) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                arb_req_d = '0;
                gnt_d     = '0;
                state_d   = IDLE;
            end
        endcase
    end

    // FSM and output registers; reset abandons any in-flight grant.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            arb_req_q <= '0;
            gnt_q     <= '0;
            wait_q    <= '0;
            drop_q    <= 1'b0;
            tout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            arb_req_q <= arb_req_d;
            gnt_q     <= gnt_d;
            wait_q    <= wait_d;
            drop_q    <= drop_d;
            tout_q    <= tout_d;
        end
    end

endmodule

// File: tb/tb_rr_grant_dispatch.sv
// Self-checking bench for rr_grant_dispatch (REQCNT=5, ARB_LAT=2, TIMEOUT=16).
module tb_rr_grant_dispatch;
    import rr_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [4:0] cli_req_i = '0;
    logic [4:0] cli_full_o;
    logic [4:0] arb_req_o;
    logic [2:0] arb_num_i = '0;
    logic       arb_num_val_i = 1'b0;
    logic [4:0] gnt_o;
    logic       gnt_val_o;
    logic       gnt_ready_i = 1'b0;
    logic       drop_o;
    logic       timeout_o;

    int n_chk  = 0;
    int n_pass = 0;

    rr_grant_dispatch #(
        .REQCNT(5), .REQWIDTH(3), .CNTWIDTH(4), .ARB_LAT(2), .TIMEOUT(16)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cli_req_i(cli_req_i), .cli_full_o(cli_full_o),
        .arb_req_o(arb_req_o), .arb_num_i(arb_num_i), .arb_num_val_i(arb_num_val_i),
        .gnt_o(gnt_o), .gnt_val_o(gnt_val_o), .gnt_ready_i(gnt_ready_i),
        .drop_o(drop_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model state, advanced at every rising edge.
    int       m_cnt [5];
    bit       m_wait, m_offer, m_drop, m_tout;
    int       m_age, m_num;
    bit [4:0] m_mask;

    task automatic model_edge();
        int  old [5];
        bit  hs;
        bit  inc, dec;
        bit [4:0] pend;
        int  n;
        if (!rst_i) begin
            for (int i = 0; i < 5; i++) m_cnt[i] = 0;
            m_wait = 0; m_offer = 0; m_drop = 0; m_tout = 0;
            m_age = 0; m_num = 0; m_mask = '0;
            return;
        end
        old = m_cnt;
        hs  = m_offer && gnt_ready_i;
        m_drop = 0;
        m_tout = 0;
        for (int i = 0; i < 5; i++) begin
            inc = cli_req_i[i];
            dec = hs && (m_num == i);
            if (inc && dec) begin
            end else if (inc) begin
                if (m_cnt[i] < 15) m_cnt[i]++;
            end else if (dec) begin
                m_cnt[i]--;
            end
        end
        if (m_offer) begin
            if (gnt_ready_i) m_offer = 0;
        end else if (m_wait) begin
            n = int'(arb_num_i);
            if (m_age >= 2 && arb_num_val_i) begin
                m_wait = 0;
                if (n < 5 && m_mask[n]) begin
                    m_offer = 1;
                    m_num   = n;
                end else begin
                    m_drop = 1;
                end
            end else if (m_age == 15) begin
                m_wait = 0;
                m_tout = 1;
            end else begin
                m_age++;
            end
        end else begin
            pend = '0;
            for (int i = 0; i < 5; i++) pend[i] = (old[i] != 0);
            if (pend != 0) begin
                m_mask = pend;
                m_wait = 1;
                m_age  = 0;
            end
        end
    endtask

    function automatic logic [63:0] model_vec();
        logic [19:0] c;
        logic [4:0]  full;
        logic [4:0]  g;
        for (int i = 0; i < 5; i++) begin
            c[i*4 +: 4] = 4'(m_cnt[i]);
            full[i]     = (m_cnt[i] == 15);
        end
        g = m_offer ? (5'b00001 << m_num) : 5'b0;
        return {26'b0, c, (m_wait ? m_mask : 5'b0), g, m_offer, m_drop, m_tout, full};
    endfunction

    function automatic logic [19:0] dut_cnts();
        logic [19:0] c;
        for (int i = 0; i < 5; i++) c[i*4 +: 4] = dut.cnt_w[i];
        return c;
    endfunction

    function automatic logic [17:0] outs();
        return {arb_req_o, gnt_o, gnt_val_o, drop_o, timeout_o, cli_full_o};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        cli_req_i = '0; arb_num_val_i = 1'b0; arb_num_i = '0; gnt_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b0;
        step();
        step();
        rst_i = 1'b1;
    endtask

    task automatic wait_gval(input int budget);
        int k = 0;
        while (!gnt_val_o && k < budget) begin
            step();
            k++;
        end
        chk("wait_gval", 64'(gnt_val_o), 64'd1);
    endtask

    typedef struct {
        logic [4:0] req;
        logic       val;
        logic [2:0] num;
        logic       rdy;
        logic [4:0] e_arb;
        logic [4:0] e_gnt;
        logic       e_gval;
        logic [3:0] e_cnt2;
    } vec_t;

    vec_t tbl [7];

    initial begin
        // Single request on client 2; arbiter answers 2 from the first cycle
        // of WAIT_GNT, but only the answer at wait count ARB_LAT is taken.
        tbl[0] = '{5'b00100, 1'b0, 3'd0, 1'b1, 5'b00000, 5'b00000, 1'b0, 4'd1};
        tbl[1] = '{5'b00000, 1'b0, 3'd0, 1'b1, 5'b00100, 5'b00000, 1'b0, 4'd1};
        tbl[2] = '{5'b00000, 1'b1, 3'd2, 1'b1, 5'b00100, 5'b00000, 1'b0, 4'd1};
        tbl[3] = '{5'b00000, 1'b1, 3'd2, 1'b1, 5'b00100, 5'b00000, 1'b0, 4'd1};
        tbl[4] = '{5'b00000, 1'b1, 3'd2, 1'b1, 5'b00000, 5'b00100, 1'b1, 4'd1};
        tbl[5] = '{5'b00000, 1'b0, 3'd0, 1'b1, 5'b00000, 5'b00000, 1'b0, 4'd0};
        tbl[6] = '{5'b00000, 1'b0, 3'd0, 1'b1, 5'b00000, 5'b00000, 1'b0, 4'd0};

        // Reset release with no requests.
        do_reset();
        chk("reset_outs", 64'(outs()), 64'd0);
        chk("reset_cnts", 64'(dut_cnts()), 64'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("quiet_outs", 64'(outs()), 64'd0);
            chk("quiet_state", 64'(dut.state_q), 64'(IDLE));
        end

        // Single request, table driven.
        for (int r = 0; r < 7; r++) begin
            cli_req_i = tbl[r].req; arb_num_val_i = tbl[r].val;
            arb_num_i = tbl[r].num; gnt_ready_i = tbl[r].rdy;
            step();
            chk($sformatf("single_arb[%0d]", r), 64'(arb_req_o), 64'(tbl[r].e_arb));
            chk($sformatf("single_gnt[%0d]", r), 64'(gnt_o), 64'(tbl[r].e_gnt));
            chk($sformatf("single_gval[%0d]", r), 64'(gnt_val_o), 64'(tbl[r].e_gval));
            chk($sformatf("single_cnt2[%0d]", r), 64'(dut.cnt_w[2]), 64'(tbl[r].e_cnt2));
        end
        idle_inputs();

        // Full counter, then increment and handshake in the same cycle.
        do_reset();
        cli_req_i = 5'b00001;
        for (int i = 0; i < 15; i++) step();
        chk("full_cnt15", 64'(dut.cnt_w[0]), 64'd15);
        chk("full_flag", 64'(cli_full_o), 64'b00001);
        step();
        chk("full_ignore16", 64'(dut.cnt_w[0]), 64'd15);
        cli_req_i = '0; arb_num_val_i = 1'b1; arb_num_i = 3'd0; gnt_ready_i = 1'b0;
        wait_gval(40);
        chk("full_gnt", 64'(gnt_o), 64'b00001);
        cli_req_i = 5'b00001; gnt_ready_i = 1'b1; arb_num_val_i = 1'b0;
        step();
        chk("simul_cnt", 64'(dut.cnt_w[0]), 64'd15);
        chk("simul_gval", 64'(gnt_val_o), 64'd0);
        idle_inputs();

        // Bad grants: out-of-mask number, then out-of-range number.
        do_reset();
        cli_req_i = 5'b00010;
        step();
        cli_req_i = '0;
        step();
        chk("bad_arb", 64'(arb_req_o), 64'b00010);
        arb_num_val_i = 1'b1; arb_num_i = 3'd3;
        step(); step();
        chk("bad_nodrop_early", 64'(drop_o), 64'd0);
        step();
        chk("bad_drop3", 64'({drop_o, gnt_val_o, arb_req_o}), 64'({1'b1, 1'b0, 5'b0}));
        arb_num_i = 3'd6;
        step();
        chk("bad_rearb", 64'({drop_o, arb_req_o}), 64'({1'b0, 5'b00010}));
        step(); step(); step();
        chk("bad_drop6", 64'({drop_o, gnt_val_o}), 64'({1'b1, 1'b0}));
        chk("bad_cnt1", 64'(dut.cnt_w[1]), 64'd1);
        idle_inputs();

        // Timeout: arbiter never answers.
        do_reset();
        cli_req_i = 5'b01000;
        step();
        cli_req_i = '0;
        step();
        chk("to_arb_rise", 64'(arb_req_o), 64'b01000);
        for (int i = 0; i < 15; i++) step();
        chk("to_not_yet", 64'({timeout_o, arb_req_o}), 64'({1'b0, 5'b01000}));
        step();
        chk("to_pulse", 64'({timeout_o, arb_req_o}), 64'({1'b1, 5'b0}));
        step();
        chk("to_rearb", 64'({timeout_o, arb_req_o}), 64'({1'b0, 5'b01000}));

        // Backpressure, then reset in the middle of the offer.
        do_reset();
        cli_req_i = 5'b10000;
        step();
        cli_req_i = '0; arb_num_val_i = 1'b1; arb_num_i = 3'd4; gnt_ready_i = 1'b0;
        wait_gval(20);
        arb_num_val_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_stable", 64'({gnt_val_o, gnt_o}), 64'({1'b1, 5'b10000}));
        end
        rst_i = 1'b0;
        step();
        rst_i = 1'b1;
        chk("bp_rst_outs", 64'(outs()), 64'd0);
        chk("bp_rst_cnts", 64'(dut_cnts()), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_after_rst", 64'(outs()), 64'd0);
        end

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < 5; i++) cli_req_i[i] = ($urandom_range(0, 3) == 0);
            arb_num_val_i = ($urandom_range(0, 1) == 1);
            arb_num_i     = 3'($urandom_range(0, 7));
            gnt_ready_i   = ($urandom_range(0, 4) < 3);
            rst_i         = ($urandom_range(0, 199) != 0);
            step();
            chk("rand", {26'b0, dut_cnts(), outs()}, model_vec());
        end
        rst_i = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
